memd_store_buffer: RTL and testbench

//  Write side of the data memory; the core's load path only reads it. Accepts committed stores from
//  the commit stage, holds them in program order in a circular FIFO, and drains one per handshake
//  to the memd write port. Loads get a combinational, youngest-first forwarding lookup over pending

---
 rtl/memd_store_buffer_pkg.sv | 17 +
 rtl/memd_store_buffer_fwd.sv | 40 ++++
 rtl/memd_store_buffer.sv | 94 +++++++++
 tb/tb_memd_store_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/memd_store_buffer_pkg.sv
// rtl/memd_store_buffer_pkg.sv - shared sizes for the memd store buffer
package memd_store_buffer_pkg;

   localparam int SB_DEPTH     = 4;
   localparam int SB_DEPTH_LOG = 2;
   localparam int ADDR_LEN     = 8;
   localparam int DATA_LEN     = 32;

   localparam logic [SB_DEPTH_LOG-1:0] PTR_ONE  = SB_DEPTH_LOG'(1);
   localparam logic [SB_DEPTH_LOG:0]   CNT_ONE  = (SB_DEPTH_LOG+1)'(1);
   localparam logic [SB_DEPTH_LOG:0]   FULL_CNT = (SB_DEPTH_LOG+1)'(SB_DEPTH);

   function automatic logic [SB_DEPTH_LOG-1:0] sb_ptr_inc(input logic [SB_DEPTH_LOG-1:0] p);
      return p + PTR_ONE;
   endfunction

endpackage

// File: rtl/memd_store_buffer_fwd.sv
// rtl/memd_store_buffer_fwd.sv - youngest-match load forwarding over pending stores
module sb_fwd_match
   import memd_store_buffer_pkg::*;
(
   input  logic [SB_DEPTH-1:0]                valid_i,
   input  logic [SB_DEPTH-1:0][ADDR_LEN-1:0]  addr_i,
   input  logic [SB_DEPTH-1:0][DATA_LEN-1:0]  data_i,
   input  logic [SB_DEPTH_LOG-1:0]            head_i,
   input  logic [SB_DEPTH_LOG-1:0]            tail_i,
   input  logic [ADDR_LEN-1:0]                ld_addr_i,
   output logic                               hit_o,
   output logic [DATA_LEN-1:0]                data_o
);

   logic [SB_DEPTH_LOG-1:0] span;
   logic [SB_DEPTH_LOG-1:0] idx;
   logic [SB_DEPTH_LOG-1:0] off;
   logic                    in_win;

   // Walk oldest to youngest from head; a later match overrides, so the youngest wins.
   // span==0 with a valid head means the buffer is full and every slot is in the window.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      span   = tail_i - head_i;
      idx    = head_i;
      off    = '0;
      in_win = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         off    = SB_DEPTH_LOG'(i);
         idx    = head_i + off;
         in_win = (off < span) || ((span == '0) && valid_i[head_i]);
         if (in_win && valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
            hit_o  = 1'b1;
            data_o = data_i[idx];
         end
      end
   end

endmodule

// File: rtl/memd_store_buffer.sv
// rtl/memd_store_buffer.sv - in-order committed-store FIFO draining to the memd write port
module memd_store_buffer
   import memd_store_buffer_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    st_valid_i,
   output logic                    st_ready_o,
   input  logic [ADDR_LEN-1:0]     st_addr_i,
   input  logic [DATA_LEN-1:0]     st_data_i,
   output logic                    wr_en_o,
   output logic [ADDR_LEN-1:0]     wr_addr_o,
   output logic [DATA_LEN-1:0]     wr_data_o,
   input  logic                    wr_ack_i,
   input  logic [ADDR_LEN-1:0]     ld_addr_i,
   output logic                    ld_hit_o,
   output logic [DATA_LEN-1:0]     ld_data_o,
   output logic [SB_DEPTH_LOG:0]   sb_count_o,
   output logic                    sb_empty_o
);

   logic [SB_DEPTH-1:0][ADDR_LEN-1:0] addr_q;
   logic [SB_DEPTH-1:0][DATA_LEN-1:0] data_q;
   logic [SB_DEPTH-1:0]               valid_q, valid_d;
   logic [SB_DEPTH_LOG-1:0]           head_q, head_d;
   logic [SB_DEPTH_LOG-1:0]           tail_q, tail_d;
   logic [SB_DEPTH_LOG:0]             count_q, count_d;
   logic                              push, pop;

   // Full/empty come from count because head==tail is ambiguous after wrap.
   assign st_ready_o = (count_q != FULL_CNT);
   assign sb_empty_o = (count_q == '0);
   assign sb_count_o = count_q;
   assign wr_en_o    = !sb_empty_o;
   assign wr_addr_o  = wr_en_o ? addr_q[head_q] : '0;
   assign wr_data_o  = wr_en_o ? data_q[head_q] : '0;

   assign push = st_valid_i && st_ready_o;
   assign pop  = wr_en_o && wr_ack_i;

   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = sb_ptr_inc(tail_q);
      end
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = sb_ptr_inc(head_q);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload needs no reset: every read of it is qualified by valid or count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= st_addr_i;
         data_q[tail_q] <= st_data_i;
      end
   end

   sb_fwd_match u_fwd (
      .valid_i   (valid_q),
      .addr_i    (addr_q),
      .data_i    (data_q),
      .head_i    (head_q),
      .tail_i    (tail_q),
      .ld_addr_i (ld_addr_i),
      .hit_o     (ld_hit_o),
      .data_o    (ld_data_o)
   );

endmodule

// File: tb/tb_memd_store_buffer.sv
// tb/tb_memd_store_buffer.sv - directed self-checking bench for memd_store_buffer
module tb_memd_store_buffer;
   import memd_store_buffer_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  st_valid_i;
   logic                  st_ready_o;
   logic [ADDR_LEN-1:0]   st_addr_i;
   logic [DATA_LEN-1:0]   st_data_i;
   logic                  wr_en_o;
   logic [ADDR_LEN-1:0]   wr_addr_o;
   logic [DATA_LEN-1:0]   wr_data_o;
   logic                  wr_ack_i;
   logic [ADDR_LEN-1:0]   ld_addr_i;
   logic                  ld_hit_o;
   logic [DATA_LEN-1:0]   ld_data_o;
   logic [SB_DEPTH_LOG:0] sb_count_o;
   logic                  sb_empty_o;

   int n_chk  = 0;
   int n_pass = 0;

   logic [ADDR_LEN-1:0] exp_a[$];
   logic [DATA_LEN-1:0] exp_d[$];

   always #5 clk = ~clk;

   memd_store_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .st_valid_i (st_valid_i),
      .st_ready_o (st_ready_o),
      .st_addr_i  (st_addr_i),
      .st_data_i  (st_data_i),
      .wr_en_o    (wr_en_o),
      .wr_addr_o  (wr_addr_o),
      .wr_data_o  (wr_data_o),
      .wr_ack_i   (wr_ack_i),
      .ld_addr_i  (ld_addr_i),
      .ld_hit_o   (ld_hit_o),
      .ld_data_o  (ld_data_o),
      .sb_count_o (sb_count_o),
      .sb_empty_o (sb_empty_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Inputs change only at negedge; the store is taken at the following posedge.
   task automatic push(input logic [ADDR_LEN-1:0] a, input logic [DATA_LEN-1:0] d);
      st_valid_i = 1'b1;
      st_addr_i  = a;
      st_data_i  = d;
      @(negedge clk);
      st_valid_i = 1'b0;
   endtask

   task automatic drain_one;
      wr_ack_i = 1'b1;
      @(negedge clk);
      wr_ack_i = 1'b0;
   endtask

   initial begin
      int written;
      rst = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0;
      wr_ack_i = 1'b0; ld_addr_i = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", st_ready_o, 1);
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_empty", sb_empty_o, 1);
      chk("rst_count", sb_count_o, 0);
      chk("rst_ld_hit", ld_hit_o, 0);
      chk("rst_wr_addr", wr_addr_o, 0);

      for (int i = 0; i < 5; i++) begin
         wr_ack_i = i[0];
         @(negedge clk);
         chk("idle_ready", st_ready_o, 1);
         chk("idle_wr_en", wr_en_o, 0);
         chk("idle_empty", sb_empty_o, 1);
         chk("idle_ld_hit", ld_hit_o, 0);
      end
      wr_ack_i = 1'b0;

      push(8'd2, 32'd7);
      for (int i = 0; i < 4; i++) begin
         chk("hold_wr_en", wr_en_o, 1);
         chk("hold_wr_addr", wr_addr_o, 2);
         chk("hold_wr_data", wr_data_o, 7);
         if (i < 3) @(negedge clk);
      end
      drain_one();
      chk("acked_empty", sb_empty_o, 1);
      chk("acked_wr_en", wr_en_o, 0);
      chk("acked_wr_data", wr_data_o, 0);

      for (int i = 0; i < 4; i++) push(ADDR_LEN'(10 + i), DATA_LEN'(100 + i));
      chk("full_ready", st_ready_o, 0);
      chk("full_count", sb_count_o, 4);
      st_valid_i = 1'b1; st_addr_i = 8'd14; st_data_i = 32'd104;
      @(negedge clk);
      chk("full_reject_cnt", sb_count_o, 4);
      chk("full_head_addr", wr_addr_o, 10);
      wr_ack_i = 1'b1;
      @(negedge clk);
      wr_ack_i = 1'b0;
      chk("full_pop_cnt", sb_count_o, 3);
      chk("full_pop_ready", st_ready_o, 1);
      @(negedge clk);
      st_valid_i = 1'b0;
      chk("late_push_cnt", sb_count_o, 4);
      for (int i = 0; i < 4; i++) begin
         chk("order_addr", wr_addr_o, 32'(11 + i));
         chk("order_data", wr_data_o, 32'(101 + i));
         drain_one();
      end
      chk("order_empty", sb_empty_o, 1);

      st_valid_i = 1'b1; st_addr_i = 8'd6; st_data_i = 32'd66; ld_addr_i = 8'd6;
      #1;
      chk("same_cycle_invis", ld_hit_o, 0);
      @(negedge clk);
      st_valid_i = 1'b0;
      chk("next_cycle_hit", ld_hit_o, 1);
      chk("next_cycle_data", ld_data_o, 66);
      drain_one();
      chk("drained_miss", ld_hit_o, 0);

      push(8'd1, 32'd3);
      push(8'd1, 32'd9);
      ld_addr_i = 8'd1;
      #1;
      chk("fwd_hit", ld_hit_o, 1);
      chk("fwd_young", ld_data_o, 9);
      ld_addr_i = 8'd5;
      #1;
      chk("fwd_other_miss", ld_hit_o, 0);
      chk("fwd_miss_data", ld_data_o, 0);
      ld_addr_i = 8'd1;
      wr_ack_i = 1'b1;
      #1;
      chk("fwd_popping_vis", ld_data_o, 9);
      @(negedge clk);
      wr_ack_i = 1'b0;
      chk("fwd_after1_hit", ld_hit_o, 1);
      chk("fwd_after1_data", ld_data_o, 9);
      drain_one();
      chk("fwd_after2_hit", ld_hit_o, 0);
      chk("fwd_after2_data", ld_data_o, 0);

      // Push and ack interleave; ack skips every third cycle so the buffer fills a bit.
      written = 0;
      for (int c = 0, p = 0; c < 100 && written < 10; c++) begin
         wr_ack_i = 1'b0;
         if (wr_en_o && (c % 3 != 0)) begin
            if (exp_a.size() == 0) begin
               chk("sb_underflow", wr_en_o, 0);
            end else begin
               chk("sb_addr", wr_addr_o, 32'(exp_a.pop_front()));
               chk("sb_data", wr_data_o, exp_d.pop_front());
            end
            wr_ack_i = 1'b1;
            written++;
         end
         st_valid_i = 1'b0;
         if (p < 10 && st_ready_o) begin
            st_valid_i = 1'b1;
            st_addr_i  = ADDR_LEN'(40 + p);
            st_data_i  = DATA_LEN'(500 + 7 * p);
            exp_a.push_back(st_addr_i);
            exp_d.push_back(st_data_i);
            p++;
         end
         @(negedge clk);
         chk("cnt_max", {31'b0, (sb_count_o <= 3'd4)}, 1);
      end
      st_valid_i = 1'b0;
      wr_ack_i   = 1'b0;
      chk("sb_written", written, 10);
      chk("sb_final_empty", sb_empty_o, 1);

      for (int i = 0; i < 3; i++) push(ADDR_LEN'(20 + i), DATA_LEN'(200 + i));
      chk("pre_rst_wr_en", wr_en_o, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_count", sb_count_o, 0);
      chk("mid_rst_wr_en", wr_en_o, 0);
      for (int i = 0; i < 3; i++) begin
         ld_addr_i = ADDR_LEN'(20 + i);
         #1;
         chk("mid_rst_ld_hit", ld_hit_o, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
